prf_read_arbiter: RTL

//  Arbitrates PRF read requests from PRF_RR_COUNT requestors (IQ issue/operand paths) onto the
//  PRF_BANK_COUNT banks, each bank having PRF_READ_PORT_COUNT read ports. Per-bank rotating priority

---
 rtl/prf_read_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/prf_read_arbiter.sv
// Routes PRF read requests onto banked read ports with a rotating priority per bank.
// Grants are combinational; the bank port commands are registered for the SRAMs.
module prf_read_arbiter #(
  parameter int unsigned PR_COUNT            = 128,
  parameter int unsigned PRF_BANK_COUNT      = 4,
  parameter int unsigned PRF_READ_PORT_COUNT = 2,
  parameter int unsigned PRF_RR_COUNT        = 11,
  localparam int unsigned LOG_PR_COUNT = $clog2(PR_COUNT),
  localparam int unsigned LOG_RR       = $clog2(PRF_RR_COUNT),
  localparam int unsigned BANK_W       = $clog2(PRF_BANK_COUNT),
  localparam int unsigned ROW_W        = LOG_PR_COUNT - BANK_W
) (
  input  logic                                                     CLK,
  input  logic                                                     nRST,
  input  logic [PRF_RR_COUNT-1:0]                                  req_valid_by_rr,
  input  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0]                req_PR_by_rr,
  output logic [PRF_RR_COUNT-1:0]                                  req_ready_by_rr,
  output logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]              read_valid_by_bank_by_port,
  output logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][ROW_W-1:0]   read_row_by_bank_by_port,
  output logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][LOG_RR-1:0]  read_rr_by_bank_by_port,
  output logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]              next_read_valid_by_bank_by_port
);

  localparam int unsigned SUM_W  = LOG_RR + 1;
  localparam int unsigned CNT_W  = $clog2(PRF_READ_PORT_COUNT + 1);
  localparam int unsigned PIDX_W = (PRF_READ_PORT_COUNT > 1) ? $clog2(PRF_READ_PORT_COUNT) : 1;

  logic [PRF_BANK_COUNT-1:0][LOG_RR-1:0] ptr_q, ptr_d;

  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0]             read_valid_q, read_valid_d;
  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][ROW_W-1:0]  read_row_q, read_row_d;
  logic [PRF_BANK_COUNT-1:0][PRF_READ_PORT_COUNT-1:0][LOG_RR-1:0] read_rr_q, read_rr_d;

  logic [SUM_W-1:0]  sum;
  logic [LOG_RR-1:0] idx;
  logic [CNT_W-1:0]  cnt;

  // Each bank scans requestors starting at its pointer, wrapping modulo the
  // requestor count; ports fill in scan order and the pointer moves past the last grant.
  always_comb begin
    req_ready_by_rr = '0;
    read_valid_d    = '0;
    read_row_d      = '0;
    read_rr_d       = '0;
    ptr_d           = ptr_q;
    sum             = '0;
    idx             = '0;
    cnt             = '0;
    for (int unsigned b = 0; b < PRF_BANK_COUNT; b++) begin
      cnt = '0;
      for (int unsigned k = 0; k < PRF_RR_COUNT; k++) begin
        sum = {1'b0, ptr_q[b]} + SUM_W'(k);
        if (sum >= SUM_W'(PRF_RR_COUNT)) begin
          sum = sum - SUM_W'(PRF_RR_COUNT);
        end
        idx = sum[LOG_RR-1:0];
        if (req_valid_by_rr[idx] &&
            (req_PR_by_rr[idx][BANK_W-1:0] == BANK_W'(b)) &&
            (cnt < CNT_W'(PRF_READ_PORT_COUNT))) begin
          req_ready_by_rr[idx]                 = 1'b1;
          read_valid_d[b][cnt[PIDX_W-1:0]]     = 1'b1;
          read_row_d[b][cnt[PIDX_W-1:0]]       = req_PR_by_rr[idx][LOG_PR_COUNT-1:BANK_W];
          read_rr_d[b][cnt[PIDX_W-1:0]]        = idx;
          cnt                                  = cnt + 1'b1;
          ptr_d[b] = (idx == LOG_RR'(PRF_RR_COUNT - 1)) ? '0 : idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr_q        <= '0;
      read_valid_q <= '0;
      read_row_q   <= '0;
      read_rr_q    <= '0;
    end else begin
      ptr_q        <= ptr_d;
      read_valid_q <= read_valid_d;
      read_row_q   <= read_row_d;
      read_rr_q    <= read_rr_d;
    end
  end

  assign read_valid_by_bank_by_port      = read_valid_q;
  assign read_row_by_bank_by_port        = read_row_q;
  assign read_rr_by_bank_by_port         = read_rr_q;
  assign next_read_valid_by_bank_by_port = read_valid_d;

endmodule
